// File: rtl/spi_slave_rx.sv
`timescale 1ns/1ps
// spi_slave_rx: SPI slave receiver running entirely in the SCLK domain.
// The SPI pins are oversampled through synchronisers. Words of WIDTH bits are
// assembled on the sample edge selected by CPOL/CPHA, and each word carries a
// DC flag latched at bit DC_BIT. Completed words go into a FIFO_DEPTH-deep FIFO
// that the consumer drains with a valid/ready handshake.
//
// Ports:
//   SCLK, Rst        system clock and asynchronous active-high reset
//   SPI_CLK          SPI clock (asynchronous)
//   SPI_DATA         MOSI (asynchronous)
//   CS_n             chip select, active low (asynchronous)
//   DC_in            command/data line (asynchronous)
//   out_data/out_dc  registered FIFO head word and its DC flag
//   out_valid        FIFO non-empty
//   out_ready        consumer accepts the head word
//   level            FIFO occupancy
//   overflow         sticky flag: a completed word was dropped
//   ovf_clr          synchronous clear of overflow; wins over a same-cycle set
//   frame_end        one-cycle pulse on the synchronised CS_n rising edge
module spi_slave_rx #(
    parameter int WIDTH      = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1,
    parameter int DC_BIT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          SCLK,
    input  logic                          Rst,
    input  logic                          SPI_CLK,
    input  logic                          SPI_DATA,
    input  logic                          CS_n,
    input  logic                          DC_in,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_dc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          frame_end
);
    localparam int   CW   = $clog2(WIDTH);
    localparam int   PW   = $clog2(FIFO_DEPTH);
    localparam int   LW   = PW + 1;
    localparam logic IDLE = 1'(CPOL);
    localparam bit   RISE = (CPOL == CPHA);   // CPOL xor CPHA == 0 samples on rising

    typedef struct packed {
        logic             dc;
        logic [WIDTH-1:0] data;
    } entry_t;

    // Synchronisers: [0] stage 1, [1] stage 2, [2] history used for edge detection
    logic [2:0] clk_s, cs_s;
    logic [1:0] dat_s, dc_s;

    always_ff @(posedge SCLK or posedge Rst) begin
        if (Rst) begin
            clk_s <= {3{IDLE}};
            cs_s  <= 3'b111;
            dat_s <= '0;
            dc_s  <= '0;
        end else begin
            clk_s <= {clk_s[1:0], SPI_CLK};
            cs_s  <= {cs_s[1:0], CS_n};
            dat_s <= {dat_s[0], SPI_DATA};
            dc_s  <= {dc_s[0], DC_in};
        end
    end

    logic sample_edge, selected, sample, last, push, push_dc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic             dc_hold;
    entry_t           new_entry;

    assign sample_edge = RISE ? (clk_s[1] & ~clk_s[2]) : (~clk_s[1] & clk_s[2]);
    assign selected    = ~cs_s[1];
    assign sample      = selected & sample_edge;
    assign last        = (cnt == CW'(WIDTH - 1));
    assign push        = sample & last;
    assign sh_nxt      = (MSB_FIRST != 0) ? {sh[WIDTH-2:0], dat_s[1]} : {dat_s[1], sh[WIDTH-1:1]};
    // When the DC bit is the current bit, dc_hold has not caught it yet
    assign push_dc     = (cnt == CW'(DC_BIT)) ? dc_s[1] : dc_hold;
    assign new_entry   = '{dc: push_dc, data: sh_nxt};

    always_ff @(posedge SCLK or posedge Rst) begin
        if (Rst) begin
            cnt       <= '0;
            sh        <= '0;
            dc_hold   <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= cs_s[1] & ~cs_s[2];
            if (!selected) begin
                cnt <= '0;   // also discards any partial word
            end else if (sample) begin
                sh  <= sh_nxt;
                cnt <= last ? '0 : cnt + CW'(1);
                if (cnt == CW'(DC_BIT))
                    dc_hold <= dc_s[1];
            end
        end
    end

    // Output FIFO with a registered head copy
    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0] level_nxt;
    logic          pop, full, wr_en;

    assign pop    = out_valid & out_ready;
    assign full   = (level == LW'(FIFO_DEPTH));
    assign wr_en  = push & (~full | pop);   // full slot is freed by a same-cycle pop
    assign rd_nxt = rd_ptr + PW'(1);

    always_comb begin
        level_nxt = level;
        if (wr_en && !pop)
            level_nxt = level + LW'(1);
        else if (!wr_en && pop)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge SCLK) begin
        if (wr_en)
            mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge SCLK or posedge Rst) begin
        if (Rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            head      <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_nxt;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            // On full push+pop wr_ptr == rd_ptr; the next head sits at rd_ptr+1,
            // so overwriting the slot being popped is harmless.
            if (pop) begin
                if (level > LW'(1))
                    head <= mem[rd_nxt];
                else if (wr_en)
                    head <= new_entry;
            end else if (wr_en && level == '0) begin
                head <= new_entry;
            end
            if (ovf_clr)
                overflow <= 1'b0;
            else if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    assign out_data = head.data;
    assign out_dc   = head.dc;
endmodule

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns/1ps
module tb_spi_slave_rx;
    localparam int DEPTH = 4;

    logic SCLK = 1'b0;
    always #5 SCLK = ~SCLK;
    logic Rst;

    // DUT A: mode 0, MSB first
    logic       clk_a, dat_a, cs_a, dc_a, rdy_a, rnd_rdy, rnd_en, rdy_mux, clr_a;
    logic [7:0] data_oa;
    logic       dc_oa, vld_a, ovf_a, fe_a;
    logic [2:0] lvl_a;
    assign rdy_mux = rnd_en ? rnd_rdy : rdy_a;

    // DUT B: mode 3, LSB first, consumer always ready
    logic       clk_b, dat_b, cs_b, dc_b, rdy_b, zero_b;
    logic [7:0] data_ob;
    logic       dc_ob, vld_b, ovf_b, fe_b;
    logic [2:0] lvl_b;

    spi_slave_rx #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .DC_BIT(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .SCLK(SCLK), .Rst(Rst), .SPI_CLK(clk_a), .SPI_DATA(dat_a), .CS_n(cs_a), .DC_in(dc_a),
        .out_data(data_oa), .out_dc(dc_oa), .out_valid(vld_a), .out_ready(rdy_mux),
        .level(lvl_a), .overflow(ovf_a), .ovf_clr(clr_a), .frame_end(fe_a));

    spi_slave_rx #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .DC_BIT(1), .FIFO_DEPTH(DEPTH)) dut_b (
        .SCLK(SCLK), .Rst(Rst), .SPI_CLK(clk_b), .SPI_DATA(dat_b), .CS_n(cs_b), .DC_in(dc_b),
        .out_data(data_ob), .out_dc(dc_ob), .out_valid(vld_b), .out_ready(rdy_b),
        .level(lvl_b), .overflow(ovf_b), .ovf_clr(zero_b), .frame_end(fe_b));

    int         checks, errors, fe_cnt_a, exp_fe_a, vcnt_b, nb;
    logic [8:0] exp_qa[$];
    logic [8:0] exp_qb[$];
    logic       exp_ovf;

    task automatic cyc(input int n);
        repeat (n) @(posedge SCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic mon_a();
        logic [8:0] e;
        forever begin
            @(negedge SCLK);
            if (fe_a) fe_cnt_a++;
            if (!Rst && vld_a && rdy_mux) begin
                if (exp_qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_a unexpected actual=%0h required=none", {dc_oa, data_oa});
                end else begin
                    e = exp_qa.pop_front();
                    chk("pop_a", 32'({dc_oa, data_oa}), 32'(e));
                end
            end
        end
    endtask

    task automatic mon_b();
        logic [8:0] e;
        forever begin
            @(negedge SCLK);
            if (vld_b) vcnt_b++;
            if (!Rst && vld_b && rdy_b) begin
                if (exp_qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_b unexpected actual=%0h required=none", {dc_ob, data_ob});
                end else begin
                    e = exp_qb.pop_front();
                    chk("pop_b", 32'({dc_ob, data_ob}), 32'(e));
                end
            end
        end
    endtask

    task automatic rnd_drive();
        forever begin
            @(posedge SCLK);
            #2 rnd_rdy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic a_cs_lo();
        cs_a = 1'b0;
        cyc(4);
    endtask

    task automatic a_cs_hi();
        cyc(4);
        cs_a = 1'b1;
        exp_fe_a++;
        cyc(6);
    endtask

    // act: 0 none, 1 out_ready pulse in the push cycle, 2 ovf_clr pulse in the push cycle
    task automatic a_word(input logic [7:0] v, input logic [7:0] dcv, input int nbits,
                          input int act, input bit lat);
        if (nbits == 8) begin
            if (exp_qa.size() < DEPTH || act == 1) exp_qa.push_back({dcv[1], v});
            else exp_ovf = 1'b1;
            if (act == 2) exp_ovf = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            dat_a = v[7-i];
            dc_a  = dcv[i];
            cyc(4);
            clk_a = 1'b1;
            if (i == 7 && lat) begin
                cyc(2); chk("lat_pre", 32'(vld_a), 32'd0);
                cyc(1); chk("lat_vld", 32'(vld_a), 32'd1);
                cyc(1);
            end else if (i == 7 && act != 0) begin
                cyc(2);
                if (act == 1) rdy_a = 1'b1; else clr_a = 1'b1;
                cyc(1);
                rdy_a = 1'b0; clr_a = 1'b0;
                cyc(1);
            end else begin
                cyc(4);
            end
            clk_a = 1'b0;
        end
    endtask

    task automatic b_word(input logic [7:0] v, input logic [7:0] dcv);
        exp_qb.push_back({dcv[1], v});
        nb++;
        for (int i = 0; i < 8; i++) begin
            clk_b = 1'b0;          // leading edge carries no data in mode 3
            dat_b = v[i];
            dc_b  = dcv[i];
            cyc(4);
            clk_b = 1'b1;
            cyc(4);
        end
    endtask

    task automatic drain_a();
        rdy_a = 1'b1;
        cyc(8);
        rdy_a = 1'b0;
        chk("drain_level", 32'(lvl_a), 32'(exp_qa.size()));
    endtask

    initial begin
        bit in_frame;
        Rst = 1'b1;
        clk_a = 0; dat_a = 0; cs_a = 1; dc_a = 0; rdy_a = 0; rnd_en = 0; rnd_rdy = 0; clr_a = 0;
        clk_b = 1; dat_b = 0; cs_b = 1; dc_b = 0; rdy_b = 1; zero_b = 0;
        checks = 0; errors = 0; fe_cnt_a = 0; exp_fe_a = 0; vcnt_b = 0; nb = 0; exp_ovf = 0;
        fork
            mon_a();
            mon_b();
            rnd_drive();
            begin
                #1_000_000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
        join_none

        cyc(3);
        chk("rst_valid", 32'(vld_a), 32'd0);
        chk("rst_data", 32'(data_oa), 32'd0);
        chk("rst_dc", 32'(dc_oa), 32'd0);
        chk("rst_level", 32'(lvl_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_fe", 32'(fe_a), 32'd0);
        Rst = 1'b0;
        cyc(2);

        // Mode 0 single word with latency check
        a_cs_lo();
        a_word(8'hA5, 8'h07, 8, 0, 1'b1);
        chk("t1_level", 32'(lvl_a), 32'd1);
        chk("t1_data", 32'(data_oa), 32'hA5);
        chk("t1_dc", 32'(dc_oa), 32'd1);
        drain_a();
        a_cs_hi();

        // Mode 3 LSB first: stream 1,0,1,1,0,0,0,0 is word 0x0D
        cs_b = 1'b0;
        cyc(4);
        b_word(8'h0D, 8'h02);
        for (int k = 0; k < 4; k++) b_word(8'($urandom), 8'($urandom));
        cyc(4);
        cs_b = 1'b1;
        cyc(8);

        // Randomised traffic on A with a random consumer
        rnd_en = 1'b1;
        in_frame = 0;
        for (int k = 0; k < 16; k++) begin
            if (!in_frame) begin a_cs_lo(); in_frame = 1; end
            a_word(8'($urandom), 8'($urandom), 8, 0, 1'b0);
            if ($urandom_range(0, 1) == 1) begin a_cs_hi(); in_frame = 0; end
        end
        if (in_frame) a_cs_hi();
        rnd_en = 1'b0;
        drain_a();

        // Overflow and ovf_clr priority
        a_cs_lo();
        for (int k = 1; k <= 5; k++) a_word(8'(k), 8'($urandom), 8, 0, 1'b0);
        chk("ovf_level", 32'(lvl_a), 32'd4);
        chk("ovf_set", 32'(ovf_a), 32'(exp_ovf));
        clr_a = 1'b1; cyc(1); clr_a = 1'b0; exp_ovf = 1'b0; cyc(1);
        chk("ovf_clr", 32'(ovf_a), 32'(exp_ovf));
        a_word(8'h06, 8'h00, 8, 2, 1'b0);
        cyc(1);
        chk("ovf_clr_prio", 32'(ovf_a), 32'(exp_ovf));
        a_word(8'h07, 8'h00, 8, 0, 1'b0);
        chk("ovf_reset", 32'(ovf_a), 32'(exp_ovf));
        clr_a = 1'b1; cyc(1); clr_a = 1'b0; exp_ovf = 1'b0; cyc(1);
        chk("ovf_clr2", 32'(ovf_a), 32'(exp_ovf));
        a_cs_hi();
        drain_a();

        // Full FIFO with a pop in the push cycle
        a_cs_lo();
        for (int k = 1; k <= 4; k++) a_word(8'(k), 8'($urandom), 8, 0, 1'b0);
        a_word(8'h05, 8'hFF, 8, 1, 1'b0);
        chk("full_pop_level", 32'(lvl_a), 32'd4);
        chk("full_pop_ovf", 32'(ovf_a), 32'(exp_ovf));
        a_cs_hi();
        drain_a();

        // Partial word discarded, then a clean frame
        a_cs_lo();
        a_word(8'hFF, 8'hFF, 5, 0, 1'b0);
        a_cs_hi();
        chk("partial_level", 32'(lvl_a), 32'd0);
        chk("partial_fe", 32'(fe_cnt_a), 32'(exp_fe_a));
        a_cs_lo();
        a_word(8'h3C, 8'h00, 8, 0, 1'b0);
        a_cs_hi();
        chk("after_partial_data", 32'(data_oa), 32'h3C);
        drain_a();

        // Reset with words buffered and a word in flight
        a_cs_lo();
        for (int k = 0; k < 3; k++) a_word(8'($urandom), 8'($urandom), 8, 0, 1'b0);
        a_word(8'h99, 8'h00, 4, 0, 1'b0);
        Rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(vld_a), 32'd0);
        chk("mid_rst_data", 32'(data_oa), 32'd0);
        chk("mid_rst_level", 32'(lvl_a), 32'd0);
        chk("mid_rst_dc", 32'(dc_oa), 32'd0);
        exp_qa.delete();
        exp_ovf = 1'b0;
        cs_a = 1'b1; clk_a = 1'b0;
        cyc(3);
        Rst = 1'b0;
        cyc(2);
        a_cs_lo();
        a_word(8'h77, 8'h00, 8, 0, 1'b0);
        a_cs_hi();
        chk("post_rst_level", 32'(lvl_a), 32'd1);
        chk("post_rst_data", 32'(data_oa), 32'h77);
        drain_a();

        cyc(10);
        chk("end_qa_empty", 32'(exp_qa.size()), 32'd0);
        chk("end_qb_empty", 32'(exp_qb.size()), 32'd0);
        chk("b_valid_cycles", 32'(vcnt_b), 32'(nb));
        chk("fe_count", 32'(fe_cnt_a), 32'(exp_fe_a));
        chk("end_ovf", 32'(ovf_a), 32'(exp_ovf));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
